// File: rtl/data_mem_responder.sv
// Wait-state data memory responder: a small word store behind an
// IDLE/ACCESS/DONE handshake with a programmable access latency.
module data_mem_responder #(
  parameter int N     = 32,
  parameter int DEPTH = 64,
  parameter int BASE  = 1024,
  parameter int WAIT  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         MEM_R_ENIn,
  input  logic         MEM_W_ENIn,
  input  logic [N-1:0] ALU_ResIn,
  input  logic [N-1:0] Value_RmIn,
  output logic         ready,
  output logic [N-1:0] resultOut,
  output logic         errOut
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [N-1:0] LO = N'(BASE);
  localparam logic [N-1:0] HI = N'(BASE + 4 * DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [N-1:0] addr_q, addr_d;
  logic [N-1:0] wdata_q, wdata_d;
  logic         rd_q, rd_d;
  logic         wr_q, wr_d;
  logic         dual_q, dual_d;
  logic [N-1:0] result_q, result_d;
  logic         err_q, err_d;
  logic [N-1:0] mem_q [DEPTH];

  logic         req;
  logic         enter_done;
  logic         mem_we;
  logic [N-1:0] op_addr;
  logic [N-1:0] op_wdata;
  logic         op_rd;
  logic         op_wr;
  logic         op_dual;
  logic         op_in_range;
  logic [N-1:0] op_offs;
  logic [AW-1:0] op_idx;

  assign req = MEM_R_ENIn | MEM_W_ENIn;

  // Operand view for the completing access: with zero wait states the
  // access finishes on the capture edge, so the live inputs are used.
  always_comb begin
    if (state_q == IDLE) begin
      op_addr  = ALU_ResIn;
      op_wdata = Value_RmIn;
      op_wr    = MEM_W_ENIn;
      op_rd    = MEM_R_ENIn & ~MEM_W_ENIn;
      op_dual  = MEM_R_ENIn & MEM_W_ENIn;
    end else begin
      op_addr  = addr_q;
      op_wdata = wdata_q;
      op_wr    = wr_q;
      op_rd    = rd_q;
      op_dual  = dual_q;
    end
    op_in_range = (op_addr >= LO) && (op_addr < HI);
    op_offs     = op_addr - LO;
    op_idx      = AW'(op_offs >> 2);
  end

  // Handshake: stall while a request is pending or being served.
  always_comb begin
    ready = 1'b0;
    unique case (state_q)
      IDLE:    ready = ~req;
      ACCESS:  ready = 1'b0;
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // Next-state, capture and completion logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    dual_d     = dual_q;
    result_d   = result_q;
    err_d      = 1'b0;
    enter_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = ALU_ResIn;
          wdata_d = Value_RmIn;
          wr_d    = MEM_W_ENIn;
          rd_d    = MEM_R_ENIn & ~MEM_W_ENIn;
          dual_d  = MEM_R_ENIn & MEM_W_ENIn;
          cnt_d   = 4'(WAIT);
          if (WAIT == 0) begin
            state_d    = DONE;
            enter_done = 1'b1;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d      = 4'd0;
          state_d    = DONE;
          enter_done = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (enter_done) begin
      if (op_rd) begin
        result_d = op_in_range ? mem_q[op_idx] : '0;
      end
      err_d = ~op_in_range | op_dual;
    end
  end

  assign mem_we = enter_done & op_wr & op_in_range;

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      dual_q   <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      dual_q   <= dual_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // Word storage, cleared by reset; commits only when an access completes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[op_idx] <= op_wdata;
    end
  end

  assign resultOut = result_q;
  assign errOut    = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder: one instance with four wait
// states, one with none, both checked against an array-based model.
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic        r_en  [2];
  logic        w_en  [2];
  logic [31:0] addr  [2];
  logic [31:0] wdat  [2];
  logic        rdy   [2];
  logic [31:0] res   [2];
  logic        err   [2];

  logic [31:0] mem_m [2][64];
  logic [31:0] res_m [2];

  int checks;
  int errors;

  data_mem_responder #(
    .N(32), .DEPTH(64), .BASE(1024), .WAIT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .MEM_R_ENIn(r_en[0]), .MEM_W_ENIn(w_en[0]),
    .ALU_ResIn(addr[0]), .Value_RmIn(wdat[0]),
    .ready(rdy[0]), .resultOut(res[0]), .errOut(err[0])
  );

  data_mem_responder #(
    .N(32), .DEPTH(64), .BASE(1024), .WAIT(0)
  ) dut0 (
    .clk(clk), .rst(rst),
    .MEM_R_ENIn(r_en[1]), .MEM_W_ENIn(w_en[1]),
    .ALU_ResIn(addr[1]), .Value_RmIn(wdat[1]),
    .ready(rdy[1]), .resultOut(res[1]), .errOut(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      res_m[d] = '0;
      for (int i = 0; i < 64; i++) mem_m[d][i] = '0;
    end
  endtask

  task automatic idle_inputs(input int d);
    r_en[d] = 1'b0;
    w_en[d] = 1'b0;
    addr[d] = '0;
    wdat[d] = '0;
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic do_reset();
    rst = 1'b0;
    idle_inputs(0);
    idle_inputs(1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    clear_model();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", 32'(rdy[d]), 32'd1);
      chk("rst_result", res[d], 32'h0);
      chk("rst_err", 32'(err[d]), 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  // One full transaction on instance d: WAIT+1 stall cycles, then DONE.
  task automatic access(input int d, input bit r, input bit w,
                        input logic [31:0] a, input logic [31:0] v);
    int  lat;
    bit  in_rng;
    int  idx;
    bit  exp_err;
    lat     = (d == 0) ? 4 : 0;
    in_rng  = (a >= 32'd1024) && (a < 32'd1280);
    idx     = int'((a - 32'd1024) >> 2);
    exp_err = !in_rng || (r && w);
    r_en[d] = r;
    w_en[d] = w;
    addr[d] = a;
    wdat[d] = v;
    for (int i = 0; i <= lat; i++) begin
      @(negedge clk);
      chk("stall_ready", 32'(rdy[d]), 32'd0);
      chk("stall_err", 32'(err[d]), 32'd0);
      chk("stall_hold", res[d], res_m[d]);
      @(posedge clk);
      #1;
    end
    if (w && in_rng) mem_m[d][idx] = v;
    else if (r && !w) res_m[d] = in_rng ? mem_m[d][idx] : 32'h0;
    r_en[d] = $urandom_range(0, 1);
    w_en[d] = $urandom_range(0, 1);
    addr[d] = $urandom;
    wdat[d] = $urandom;
    @(negedge clk);
    chk("done_ready", 32'(rdy[d]), 32'd1);
    chk("done_err", 32'(err[d]), 32'(exp_err));
    chk("done_result", res[d], res_m[d]);
    @(posedge clk);
    #1;
    idle_inputs(d);
  endtask

  task automatic idle_check(input int d);
    @(negedge clk);
    chk("idle_ready", 32'(rdy[d]), 32'd1);
    chk("idle_err", 32'(err[d]), 32'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k < 7) return 32'd1024 + 32'($urandom_range(0, 255));
    if (k == 7) return $urandom;
    case ($urandom_range(0, 3))
      0:       return 32'd1023;
      1:       return 32'd1280;
      2:       return 32'd1279;
      default: return 32'd1024;
    endcase
  endfunction

  initial begin
    bit r;
    bit w;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    idle_inputs(0);
    idle_inputs(1);
    clear_model();
    @(posedge clk);
    #1;
    do_reset();

    access(0, 0, 1, 32'd1028, 32'hDEADBEEF);
    access(0, 1, 0, 32'd1028, 32'h0);
    idle_check(0);

    access(0, 1, 0, 32'h0, 32'h0);
    access(0, 0, 1, 32'd1280, 32'h11112222);
    access(0, 1, 0, 32'd1276, 32'h0);
    access(0, 1, 0, 32'd1024, 32'h0);

    r_en[0] = 1'b0;
    w_en[0] = 1'b1;
    addr[0] = 32'd1032;
    wdat[0] = 32'h12345678;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    idle_inputs(0);
    rst = 1'b1;
    clear_model();
    idle_check(0);
    access(0, 1, 0, 32'd1032, 32'h0);
    chk("rst_abort", res[0], 32'h0);

    access(0, 1, 0, 32'd1028, 32'h0);
    access(0, 1, 1, 32'd1036, 32'hA5A5A5A5);
    access(0, 1, 0, 32'd1036, 32'h0);

    access(1, 0, 1, 32'd1024, 32'hCAFEF00D);
    access(1, 0, 1, 32'd1028, 32'h0BADC0DE);
    access(1, 1, 0, 32'd1024, 32'h0);
    access(1, 1, 0, 32'd1028, 32'h0);
    idle_check(1);

    for (int n = 0; n < 120; n++) begin
      int d;
      d = $urandom_range(0, 1);
      r = $urandom_range(0, 1);
      w = $urandom_range(0, 1);
      if (!r && !w) r = 1'b1;
      if ($urandom_range(0, 5) == 0) r = 1'b1;
      access(d, r, w, rand_addr(), $urandom);
      if ($urandom_range(0, 3) == 0) idle_check(d);
    end

    for (int i = 0; i < 64; i++) begin
      access(0, 1, 0, 32'd1024 + 32'(i * 4), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameters SHALL be: N, 32, data/address width; DEPTH, 64, words of storage; BASE, 1024, first mapped byte address; WAIT, 4, access wait cycles (0..15).
REQ-002 Ports SHALL be, in order:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- MEM_R_ENIn  in  1  read request
- MEM_W_ENIn  in  1  write request
- ALU_ResIn  in  N  byte address
- Value_RmIn  in  N  write data
- ready  out  1  high = requester may advance
- resultOut  out  N  read data
- errOut  out  1  access error flag
REQ-003 The block SHALL use one clock, clk; reset rst SHALL be synchronous and active-low (sampled only on rising clk, asserted when 0).

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, ACCESS, DONE.
REQ-005 A request SHALL exist when MEM_R_ENIn or MEM_W_ENIn is 1.
REQ-006 ready SHALL be 1 in IDLE with no request, 0 in IDLE with a request, 0 in ACCESS, and 1 in DONE.
REQ-007 IDLE with a request at edge T SHALL capture address, write data and operation into internal registers, load the wait counter with WAIT, and go to ACCESS; if WAIT=0, it SHALL go directly to DONE.
REQ-008 ACCESS SHALL decrement the counter each cycle and go to DONE on the edge where the counter equals 1.
REQ-009 For request first presented in cycle T, ready SHALL be 0 for cycles T..T+WAIT and 1 in cycle T+WAIT+1 (DONE); total latency is WAIT+1 stall cycles.
REQ-010 DONE SHALL always return to IDLE on the next edge, regardless of inputs.
REQ-011 The requester SHALL hold request inputs stable while ready=0; inputs sampled in DONE SHALL be ignored.
REQ-012 Word index SHALL be (addr - BASE) >> 2; address bits [1:0] SHALL be ignored (no misalignment error).
REQ-013 An address is in range when BASE <= addr < BASE + 4*DEPTH, compared unsigned at N bits.
REQ-014 A write SHALL commit to storage on the edge entering DONE, only if in range.
REQ-015 A read SHALL register resultOut on the edge entering DONE: stored word if in range, 0 if out of range.
REQ-016 resultOut SHALL hold its value until the next read completes; writes SHALL NOT change it.
REQ-017 When both enables are 1 at capture, the block SHALL perform the write only.
REQ-018 errOut SHALL be 1 only in the DONE cycle of an access that was out of range or had both enables set; otherwise 0.
REQ-019 A new request in the IDLE cycle following DONE SHALL be captured immediately, with no bubble beyond the REQ-009 latency.

Reset
REQ-020 While rst=0 at an edge: state SHALL go to IDLE, counter to 0, resultOut to 0, errOut to 0, and all DEPTH storage words to 0.
REQ-021 Reset during ACCESS SHALL abort the access, and a pending write SHALL NOT commit.
REQ-022 Reset in the DONE cycle SHALL take priority, and the DONE-to-IDLE transition SHALL be the reset transition.
REQ-023 Immediately after reset release with no request, ready SHALL be 1.

Verification (WAIT=4)
REQ-024 Reset: hold rst=0 for 2 cycles, then rst=1 with no request -> ready=1, resultOut=0x00000000, errOut=0.
REQ-025 Write then read: write 0xDEADBEEF @1028, then read 1028 -> ready=0 for 5 cycles per access, 1 in DONE; read DONE resultOut=0xDEADBEEF; errOut=0.
REQ-026 Out of range: read @0x00000000 and write @1280 -> resultOut=0 after the read; storage unchanged; errOut=1 in each DONE cycle; latency still 5 stall cycles.
REQ-027 Reset mid-write: write 0x12345678 @1032, assert rst=0 in the 2nd ACCESS cycle, release, then read 1032 -> resultOut=0.
REQ-028 Dual enable: R=W=1, addr 1036, data 0xA5A5A5A5 -> errOut=1 in DONE; resultOut unchanged; subsequent read 1036 returns 0xA5A5A5A5.
REQ-029 Back-to-back with WAIT=0: reads of 1024 and 1028 on consecutive requests -> each access 1 stall cycle; DONE cycles two cycles apart; both values correct.
